ws2812_tx: RTL and testbench
============================

# ws2812_tx

Serializer stage that turns a frame of per-LED 24-bit colours into the single-wire WS2812 bitstream driving the `ws` pin. It sits directly downstream of the ear colour logic: the colour words feed `rgb`, and this block owns the `ws` output. It snapshots a frame on `start`, shifts it out with WS2812 bit timing, then holds the line low for the latch period.

## Interface
- `NUM_LEDS`, 7: LEDs in the chain.
- `T0H_CYC`, 4: high time of a 0 bit, in clk cycles (12 MHz ≈ 0.33 µs).
- `T1H_CYC`, 9: high time of a 1 bit, in cycles.
- `TBIT_CYC`, 15: total bit period, in cycles (1.25 µs).
- `TRST_CYC`, 3600: latch/reset low time, in cycles (300 µs).
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: frame request, sampled per cycle.
- `rgb` in NUM_LEDS×24: packed array; `rgb[i]` = {R,G,B} for LED i, with LED 0 nearest the pin.
- `busy` out 1: a frame or latch period is in progress.
- `done` out 1: one-cycle pulse at the end of each frame's latch period.
- `ws` out 1: WS2812 data line.

## Operation
- States: IDLE, SEND, LATCH.
- Reset (async) state:
  - Enters LATCH with the latch counter at 0.
  - `ws`=0, `busy`=1, `done`=0.
  - The post-reset latch never pulses `done`.
  - Any partial frame is therefore always terminated before new data.
- IDLE:
  - `busy`=0, `ws`=0.
  - `start`=1 accepts a frame. All of `rgb` is copied into a shadow register that same edge, and the state moves to SEND.
- SEND:
  - LEDs are sent in order 0 to NUM_LEDS-1.
  - Each word is sent G[7:0], R[7:0], B[7:0], MSB first (24 bits per LED).
  - Each bit lasts exactly TBIT_CYC cycles. `ws`=1 for T1H_CYC cycles (bit=1) or T0H_CYC cycles (bit=0), then 0 for the remainder.
  - Bit counter runs 0–23; LED index runs 0 to NUM_LEDS-1. Both use clog2-sized counters.
  - After the last bit of the last LED, the state moves to LATCH.
- LATCH:
  - `ws`=0 for TRST_CYC cycles, then the state returns to IDLE.
  - On the return cycle after a frame, `done`=1 for one cycle.
- Boundaries:
  - `start` while busy is ignored; there is no queueing.
  - Changes to `rgb` during SEND do not affect the frame in flight.
  - `start` in the cycle `done` is high is accepted, because the state is IDLE that cycle.
  - Reset asserted mid-SEND forces `ws` low immediately. After release, a full latch period runs before any `start` is accepted.
- Parameter constraint, checked by elaboration assertion: T0H_CYC < T1H_CYC < TBIT_CYC, and TRST_CYC ≥ 1.

## Timing
- Accept edge (`start`=1 in IDLE) to first `ws` rise: 1 cycle. `ws` is registered and goes high in the first SEND cycle.
- `busy` rises in the cycle after the accept edge.
- Frame length from first `ws` rise to `done`: NUM_LEDS·24·TBIT_CYC + TRST_CYC cycles. At defaults this is 7·24·15 + 3600 = 6120 cycles.
- `busy` falls in the same cycle `done` is high.
- After `rst_n` release, `busy` stays high for TRST_CYC cycles.
- `ws` is glitch-free: it is driven directly from a flop.

## Configuration
- `WS2812_AUTO_REFRESH_EN`:
  - Defined: `start` is ignored. On leaving LATCH, the block re-snapshots `rgb` and enters SEND in the same cycle, so it never rests in IDLE. `done` still pulses once per frame, and `busy` stays 1 continuously.
  - Undefined: frames are sent only on `start`, as described above.

## Structure
- Package `ws2812_pkg`:
  - State enum `ws2812_state_t` {IDLE, SEND, LATCH}.
  - Typedef `rgb_t` (24-bit {R,G,B}).
  - Function `to_grb(rgb_t)` returning the wire-order word.
  - Default timing localparams for a 12 MHz clock.
- Flat module, no sub-module. The per-bit cycle counter, bit/LED counters and shadow register are all in one always_ff. The latch counter reuses the cycle counter.

## Test plan
- Single frame, NUM_LEDS=2, TBIT=15, T0H=4, T1H=9, TRST=40, rgb[0]=24'h800000, rgb[1]=24'h000001, pulse `start`:
  - Requires 48 bits on `ws`: 00000000 10000000 00000000 00000000 00000000 00000001.
  - Measured high times are 4 or 9 cycles; every period is 15 cycles.
  - `done` comes 720+40 cycles after the first rise.
- Snapshot: change `rgb` to 24'hFFFFFF after accept → the transmitted bits still match the original values.
- `start` held high throughout → back-to-back frames. Each frame is separated by exactly TRST_CYC low cycles, and the next frame starts the cycle after `done`.
- `start` pulses during SEND and LATCH → ignored. Exactly one `done` is produced.
- Reset mid-frame at bit 10:
  - `ws`=0 at once, `busy`=1.
  - A `start` issued 20 cycles after release is ignored.
  - A `start` after 40 cycles is accepted.
  - No `done` is produced by the reset latch.
- With `WS2812_AUTO_REFRESH_EN` defined, no `start` → continuous frames, with `done` every 760 cycles.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared types, default 12 MHz timing and the wire-order helper for the WS2812 serializer.
package ws2812_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        LATCH
    } ws2812_state_t;

    typedef logic [23:0] rgb_t;

    localparam int DEF_NUM_LEDS = 7;
    localparam int DEF_T0H_CYC  = 4;
    localparam int DEF_T1H_CYC  = 9;
    localparam int DEF_TBIT_CYC = 15;
    localparam int DEF_TRST_CYC = 3600;
    localparam int BITS_PER_LED = 24;

    // WS2812 expects green first, then red, then blue.
    function automatic rgb_t to_grb(input rgb_t c);
        return {c[15:8], c[23:16], c[7:0]};
    endfunction

endpackage

// File: rtl/ws2812_tx.sv
// WS2812 single-wire serializer: snapshots a frame of colours and shifts it out, then latches.
// Build option WS2812_AUTO_REFRESH_EN: resend the current rgb continuously without start.
//
// state | meaning
// IDLE  | line low, waiting for start
// SEND  | shifting shadow frame out, one TBIT_CYC slot per bit
// LATCH | line low for TRST_CYC cycles (also entered from reset)
module ws2812_tx
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int T0H_CYC  = DEF_T0H_CYC,
    parameter int T1H_CYC  = DEF_T1H_CYC,
    parameter int TBIT_CYC = DEF_TBIT_CYC,
    parameter int TRST_CYC = DEF_TRST_CYC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  rgb_t [NUM_LEDS-1:0]  rgb,
    output logic                 busy,
    output logic                 done,
    output logic                 ws
);

    localparam int LW   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int BW   = $clog2(BITS_PER_LED);
    localparam int CMAX = (TRST_CYC > TBIT_CYC) ? TRST_CYC : TBIT_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    if (!(T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC && TRST_CYC >= 1)) begin : g_bad_timing
        $error("ws2812_tx: need T0H_CYC < T1H_CYC < TBIT_CYC and TRST_CYC >= 1");
    end

    ws2812_state_t       state, state_nx;
    logic [CW-1:0]       cyc;
    logic [CW-1:0]       cyc_inc;
    logic [CW-1:0]       hi_time;
    logic [BW-1:0]       bit_cnt;
    logic [LW-1:0]       led;
    rgb_t [NUM_LEDS-1:0] shadow;
    rgb_t                cur_word;
    logic                cur_bit;
    logic                framed;
    logic                bit_end;
    logic                lat_end;
    logic                last_led_bit;
    logic                last_bit;
    logic                load;

    assign cyc_inc      = cyc + 1'b1;
    assign bit_end      = (cyc == CW'(TBIT_CYC - 1));
    assign lat_end      = (cyc == CW'(TRST_CYC - 1));
    assign last_led_bit = (bit_cnt == BW'(BITS_PER_LED - 1));
    assign last_bit     = bit_end && last_led_bit && (led == LW'(NUM_LEDS - 1));
    assign cur_word     = to_grb(shadow[led]);
    assign cur_bit      = cur_word[BW'(BITS_PER_LED - 1) - bit_cnt];
    assign hi_time      = cur_bit ? CW'(T1H_CYC) : CW'(T0H_CYC);

`ifdef WS2812_AUTO_REFRESH_EN
    assign load = (state == LATCH) && lat_end;
`else
    assign load = (state == IDLE) && start;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LATCH;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load) state_nx = SEND;
            SEND:    if (last_bit) state_nx = LATCH;
            LATCH:   if (lat_end) state_nx = load ? SEND : IDLE;
            default: state_nx = LATCH;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // ws is computed one cycle ahead so the pin comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc     <= '0;
            bit_cnt <= '0;
            led     <= '0;
            shadow  <= '0;
            framed  <= 1'b0;
            done    <= 1'b0;
            ws      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                SEND: begin
                    if (bit_end) begin
                        cyc <= '0;
                        ws  <= !last_bit;
                        if (last_led_bit) begin
                            bit_cnt <= '0;
                            led     <= last_bit ? '0 : led + 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cyc <= cyc_inc;
                        ws  <= (cyc_inc < hi_time);
                    end
                end
                LATCH: begin
                    ws <= 1'b0;
                    if (lat_end) begin
                        cyc    <= '0;
                        done   <= framed;
                        framed <= 1'b0;
                    end else begin
                        cyc <= cyc_inc;
                    end
                end
                default: ws <= 1'b0;
            endcase
            if (load) begin
                shadow  <= rgb;
                cyc     <= '0;
                bit_cnt <= '0;
                led     <= '0;
                framed  <= 1'b1;
                ws      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ws2812_tx.sv
// Directed bench for ws2812_tx with a two-LED chain and a short latch period.
module tb_ws2812_tx;
    import ws2812_pkg::*;

    localparam int N     = 2;
    localparam int T0H   = 4;
    localparam int T1H   = 9;
    localparam int TBIT  = 15;
    localparam int TRST  = 40;
    localparam int NBITS = N * 24;
    localparam int FRAME = NBITS * TBIT;
    localparam int CAP   = FRAME + TRST + 40;

    typedef struct {
        rgb_t        c0;
        rgb_t        c1;
        logic [47:0] bits;
        int          mode;   // 0 plain, 1 rgb changed after accept, 2 stray starts, 3 start held
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    rgb_t [N-1:0] rgb = '0;
    logic         busy;
    logic         done;
    logic         ws;

    int   applied = 0;
    int   miscompares = 0;
    logic s_ws   [CAP];
    logic s_busy [CAP];
    logic s_done [CAP];
    vec_t vecs   [6];

    always #5 clk = ~clk;

    ws2812_tx #(
        .NUM_LEDS (N),
        .T0H_CYC  (T0H),
        .T1H_CYC  (T1H),
        .TBIT_CYC (TBIT),
        .TRST_CYC (TRST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .rgb   (rgb),
        .busy  (busy),
        .done  (done),
        .ws    (ws)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check({tag, " idle timeout"}, 64'(busy), 64'd0);
    endtask

    // Busy must stay high for exactly TRST cycles after reset release with ws low and no done.
    task automatic reset_latch(input string tag, input bit poke_start);
        int   n = 0;
        logic ok = 1'b1;
        while (busy === 1'b1 && n < 200) begin
            if (ws !== 1'b0 || done !== 1'b0) ok = 1'b0;
            start = poke_start && (n == 20);
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " latch length"}, 64'(n), 64'(TRST));
        check({tag, " latch quiet"}, 64'(ok), 64'd1);
        check({tag, " no done"}, 64'(done), 64'd0);
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        logic [47:0] got;
        logic        shape;
        logic        lat_ok;
        logic        idle_ok;
        int          ndone;
        int          hi;
        wait_idle(tag);
        @(negedge clk);
        rgb[0] = v.c0;
        rgb[1] = v.c1;
        start  = 1'b1;
        @(negedge clk);
        if (v.mode != 3) start = 1'b0;
        if (v.mode == 1) rgb = {24'hFFFFFF, 24'hFFFFFF};
        for (int i = 0; i < CAP; i++) begin
            s_ws[i]   = ws;
            s_busy[i] = busy;
            s_done[i] = done;
            if (v.mode == 2) start = (i == 100 || i == 730);
            @(negedge clk);
        end
        if (v.mode == 3) start = 1'b0;

        check({tag, " first rise"}, {62'd0, s_ws[0], s_busy[0]}, 64'd3);
        got   = '0;
        shape = 1'b1;
        for (int k = 0; k < NBITS; k++) begin
            hi = 0;
            for (int j = 0; j < TBIT; j++) begin
                if (s_ws[k*TBIT + j]) begin
                    if (j != hi) shape = 1'b0;
                    hi++;
                end
            end
            if (hi != T0H && hi != T1H) shape = 1'b0;
            got[NBITS-1-k] = (hi == T1H);
        end
        check({tag, " bits"}, 64'(got), 64'(v.bits));
        check({tag, " bit shape"}, 64'(shape), 64'd1);

        lat_ok = 1'b1;
        for (int i = FRAME; i < FRAME + TRST; i++)
            if (s_ws[i] !== 1'b0 || s_busy[i] !== 1'b1 || s_done[i] !== 1'b0) lat_ok = 1'b0;
        check({tag, " latch"}, 64'(lat_ok), 64'd1);
        check({tag, " done cycle"}, {61'd0, s_done[FRAME+TRST], s_busy[FRAME+TRST], s_ws[FRAME+TRST]},
              64'b100);
        ndone = 0;
        for (int i = 0; i < CAP; i++) if (s_done[i] === 1'b1) ndone++;
        check({tag, " done count"}, 64'(ndone), 64'd1);

        if (v.mode == 3) begin
            check({tag, " next frame"}, {62'd0, s_ws[FRAME+TRST+1], s_busy[FRAME+TRST+1]}, 64'd3);
        end else begin
            idle_ok = 1'b1;
            for (int i = FRAME + TRST + 1; i < CAP; i++)
                if (s_ws[i] !== 1'b0 || s_busy[i] !== 1'b0) idle_ok = 1'b0;
            check({tag, " idle after"}, 64'(idle_ok), 64'd1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{c0: 24'h800000, c1: 24'h000001, bits: 48'h008000_000001, mode: 0};
        vecs[1] = '{c0: 24'h00FF00, c1: 24'h0000FF, bits: 48'hFF0000_0000FF, mode: 0};
        vecs[2] = '{c0: 24'h123456, c1: 24'hABCDEF, bits: 48'h341256_CDABEF, mode: 1};
        vecs[3] = '{c0: 24'h800000, c1: 24'h000001, bits: 48'h008000_000001, mode: 2};
        vecs[4] = '{c0: 24'h000000, c1: 24'h000000, bits: 48'h000000_000000, mode: 0};
        vecs[5] = '{c0: 24'hFFFFFF, c1: 24'hFFFFFF, bits: 48'hFFFFFF_FFFFFF, mode: 3};

        #1 rst_n = 1'b0;
        #2;
        check("reset ws", 64'(ws), 64'd0);
        check("reset busy", 64'(busy), 64'd1);
        check("reset done", 64'(done), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef WS2812_AUTO_REFRESH_EN
        begin
            int   n = 0;
            logic busy_ok;
            rgb = {24'h000001, 24'h800000};
            while (done !== 1'b1 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            check("auto first done", 64'(done), 64'd1);
            for (int g = 0; g < 4; g++) begin
                n = 0;
                busy_ok = 1'b1;
                do begin
                    @(negedge clk);
                    n++;
                    if (busy !== 1'b1) busy_ok = 1'b0;
                end while (done !== 1'b1 && n < 2000);
                check("auto done period", 64'(n), 64'(FRAME + TRST));
                check("auto busy held", 64'(busy_ok), 64'd1);
                check("auto ws at done", 64'(ws), 64'd1);
            end
        end
`else
        reset_latch("por", 1'b0);
        for (int v = 0; v < 6; v++) run_frame(vecs[v], $sformatf("vec%0d", v));

        // Reset in the middle of bit 10, then a start during the reset latch.
        wait_idle("rst");
        @(negedge clk);
        rgb   = {24'h000001, 24'h800000};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10 * TBIT + 2) @(negedge clk);
        check("pre-reset ws", 64'(ws), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid reset ws", 64'(ws), 64'd0);
        check("mid reset busy", 64'(busy), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        reset_latch("mid", 1'b1);
        run_frame(vecs[1], "after reset");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
